// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-side controllers: controller state
// encoding, RAM geometry and the default access latency.
package cpu_mem_pkg;

    localparam int unsigned RAM_ADDR_W  = 9;
    localparam int unsigned MEM_LAT_DEF = 2;
    localparam int unsigned LAT_CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_WR_WAIT,
        ST_WR_DONE,
        ST_ERR
    } mem_state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Access-latency down-counter: parallel load, saturating decrement and a
// zero flag. Shared with the I/O port controller.
module mem_lat_counter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned CNT_W = LAT_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side controller: turns one-cycle read/write requests into timed RAM
// strobes and delivers read data to the MDR input mux.
module mem_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = RAM_ADDR_W,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       mar_in,
    input  logic [DATA_W-1:0] mdr_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] Mdatain,
    output logic              Read,
    output logic              mdr_load,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic              req_err
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_err_q, req_err_d;

    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;
    logic any_req;
    logic can_accept;
    logic addr_oor;

    mem_lat_counter #(
        .CNT_W (LAT_CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .clr      (clr),
        .load     (cnt_load),
        .load_val (LAT_CNT_W'(MEM_LAT - 1)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign any_req  = req_read | req_write;
    assign addr_oor = |mar_in[31:ADDR_W];
    // The done cycle also accepts, giving one request per MEM_LAT+1 cycles.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RD_CAP) ||
                        (state_q == ST_WR_DONE);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        req_err_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        case (state_q)
            ST_RD_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_RD_CAP;
                    rdata_d = mem_rdata;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_zero) begin
                    state_d = ST_WR_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RD_CAP, ST_WR_DONE, ST_ERR: state_d = ST_IDLE;
            default: ;
        endcase

        if (any_req && can_accept) begin
            addr_d    = mar_in[ADDR_W-1:0];
            cnt_load  = 1'b1;
            req_err_d = req_read & req_write;
            if (!req_read) begin
                wdata_d = mdr_in;
            end
            if (addr_oor) begin
                state_d = ST_ERR;
            end else if (req_read) begin
                state_d = ST_RD_WAIT;
            end else begin
                state_d = ST_WR_WAIT;
            end
        end else if (any_req) begin
            req_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            req_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            req_err_q <= req_err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign Mdatain   = rdata_q;
    assign mem_re    = (state_q == ST_RD_WAIT);
    assign mem_we    = (state_q == ST_WR_WAIT);
    assign Read      = (state_q == ST_RD_CAP);
    assign mdr_load  = (state_q == ST_RD_CAP);
    assign done      = (state_q == ST_RD_CAP) || (state_q == ST_WR_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign addr_err  = (state_q == ST_ERR);
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against a cycle-level
// transaction model and a shadow memory image.
module tb_mem_access_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_read;
    logic        req_write;
    logic [31:0] mar_in;
    logic [31:0] mdr_in;
    logic [31:0] mem_rdata;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] Mdatain;
    logic        Read;
    logic        mdr_load;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic        req_err;

    logic [31:0] ram     [512];
    logic [31:0] ref_mem [512];

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(
        .ADDR_W  (9),
        .DATA_W  (32),
        .MEM_LAT (LAT)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_read  (req_read),
        .req_write (req_write),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .Mdatain   (Mdatain),
        .Read      (Read),
        .mdr_load  (mdr_load),
        .busy      (busy),
        .done      (done),
        .addr_err  (addr_err),
        .req_err   (req_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h0000_1234;
    endfunction

    // Word-addressed RAM with combinational read.
    assign mem_rdata = ram[mem_addr];
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = init_val(i);
        ram[16] = 32'h0000_0001;
        forever begin
            @(posedge clk);
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string ph, input bit re, input bit we, input bit cap,
                               input bit dn, input bit bsy, input bit aerr, input bit rerr);
        check({ph, ".mem_re"},   mem_re,   re);
        check({ph, ".mem_we"},   mem_we,   we);
        check({ph, ".Read"},     Read,     cap);
        check({ph, ".mdr_load"}, mdr_load, cap);
        check({ph, ".done"},     done,     dn);
        check({ph, ".busy"},     busy,     bsy);
        check({ph, ".addr_err"}, addr_err, aerr);
        check({ph, ".req_err"},  req_err,  rerr);
    endtask

    // Read: strobe in cycles 1..LAT, capture/done in cycle LAT+1. Ends in the done cycle.
    // inj>0 issues a stray write during RD_WAIT cycle inj to the same address.
    task automatic do_read(input logic [31:0] addr, input bit both, input int inj);
        logic [31:0] exp;
        exp       = ref_mem[addr[8:0]];
        req_read  = 1'b1;
        req_write = both;
        mar_in    = addr;
        mdr_in    = $urandom;
        step();
        req_read  = 1'b0;
        req_write = 1'b0;
        mar_in    = $urandom;
        for (int k = 1; k <= LAT + 1; k++) begin
            check_cycle("rd", k <= LAT, 1'b0, k == LAT + 1, k == LAT + 1, 1'b1, 1'b0,
                        (k == 1 && both) || (inj > 0 && k == inj + 1));
            if (k <= LAT) begin
                check("rd.mem_addr", 32'(mem_addr), {23'd0, addr[8:0]});
                if (k == inj) begin
                    req_write = 1'b1;
                    mar_in    = addr;
                    mdr_in    = ~exp;
                end
                step();
                req_write = 1'b0;
            end else begin
                check("rd.Mdatain", Mdatain, exp);
            end
        end
    endtask

    // Write: strobe in cycles 1..LAT, done in cycle LAT+1. Ends in the done cycle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        req_write = 1'b1;
        mar_in    = addr;
        mdr_in    = data;
        step();
        req_write = 1'b0;
        mar_in    = $urandom;
        mdr_in    = $urandom;
        ref_mem[addr[8:0]] = data;
        for (int k = 1; k <= LAT + 1; k++) begin
            check_cycle("wr", 1'b0, k <= LAT, 1'b0, k == LAT + 1, 1'b1, 1'b0, 1'b0);
            if (k <= LAT) begin
                check("wr.mem_addr",  32'(mem_addr), {23'd0, addr[8:0]});
                check("wr.mem_wdata", mem_wdata, data);
                step();
            end
        end
    endtask

    // Out-of-range request: one ERR cycle. Ends in that cycle.
    task automatic do_err(input logic [31:0] addr, input bit is_read);
        req_read  = is_read;
        req_write = ~is_read;
        mar_in    = addr;
        mdr_in    = $urandom;
        step();
        req_read  = 1'b0;
        req_write = 1'b0;
        check_cycle("err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step();
        check_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        ref_mem[16] = 32'h0000_0001;

        clr = 1'b0; req_read = 1'b0; req_write = 1'b0;
        mar_in = '0; mdr_in = '0;
        step();
        step();
        check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.Mdatain",   Mdatain, 32'd0);
        check("reset.mem_addr",  32'(mem_addr), 32'd0);
        check("reset.mem_wdata", mem_wdata, 32'd0);
        clr = 1'b1;

        do_read(32'h0000_0010, 1'b0, 0);
        check("plan.rd10", Mdatain, 32'h0000_0001);
        idle();

        do_write(32'h0000_0020, 32'hDEAD_BEEF);
        idle();
        do_read(32'h0000_0020, 1'b0, 0);
        check("plan.rd20", Mdatain, 32'hDEAD_BEEF);
        idle();

        do_err(32'h0000_0200, 1'b1);
        idle();
        do_err(32'hFFFF_FE05, 1'b0);
        idle();

        do_read(32'h0000_0033, 1'b1, 0);
        idle();
        do_read(32'h0000_0044, 1'b0, 1);
        idle();
        do_read(32'h0000_0044, 1'b0, LAT);
        idle();

        do_write(32'h0000_0055, 32'hA5A5_0F0F);
        do_read(32'h0000_0055, 1'b0, 0);
        do_write(32'h0000_0056, 32'h1357_9BDF);
        do_write(32'h0000_0057, 32'h2468_ACE0);
        idle();

        req_read = 1'b1;
        mar_in   = 32'h0000_0077;
        step();
        req_read = 1'b0;
        step();
        clr = 1'b0;
        step();
        check_cycle("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst.Mdatain",  Mdatain, 32'd0);
        check("midrst.mem_addr", 32'(mem_addr), 32'd0);
        clr = 1'b1;
        do_read(32'h0000_0010, 1'b0, 0);
        idle();

        for (int n = 0; n < 40; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            a  = {23'd0, 9'($urandom_range(0, 511))};
            d  = $urandom;
            if (op == 0) begin
                a[31:9] = 23'($urandom_range(1, 23'h7FFFFF));
                do_err(a, 1'($urandom_range(0, 1)));
                idle();
            end else begin
                if (op <= 4) do_read(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, LAT)));
                else         do_write(a, d);
                if ($urandom_range(0, 1) == 1) idle();
            end
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
